// File: rtl/jelly_bean_taster_if.sv
// Jelly bean bus: recipe fields and command from the master,
// verdict, busy flag and statistics back from the taster.
interface jelly_bean_taster_if;
    logic [2:0] flavor;
    logic [1:0] color;
    logic       sugar_free;
    logic       sour;
    logic [1:0] command;
    logic [1:0] taste;
    logic       busy;
    logic [7:0] yummy_count;
    logic [7:0] yucky_count;

    modport master_mp (
        output flavor, color, sugar_free, sour, command,
        input  taste, busy, yummy_count, yucky_count
    );

    modport slave_mp (
        input  flavor, color, sugar_free, sour, command,
        output taste, busy, yummy_count, yucky_count
    );
endinterface

// File: rtl/jelly_bean_taster.sv
// Jelly bean taster: latches a recipe on WRITE, chews it for
// TASTE_LATENCY cycles, stores a verdict and keeps saturating
// yummy/yucky statistics. READ returns the stored verdict for one cycle.
module jelly_bean_taster #(
    parameter int unsigned TASTE_LATENCY = 2   // legal range 1..15
) (
    input  logic                   clk,
    input  logic                   rst,
    jelly_bean_taster_if.slave_mp  bus
);
    localparam logic [1:0] CMD_READ  = 2'd1;
    localparam logic [1:0] CMD_WRITE = 2'd2;

    localparam logic [1:0] T_UNKNOWN = 2'd0;
    localparam logic [1:0] T_YUMMY   = 2'd1;
    localparam logic [1:0] T_YUCKY   = 2'd2;

    localparam logic [2:0] F_APPLE     = 3'd1;
    localparam logic [2:0] F_CHOCOLATE = 3'd4;
    localparam logic [1:0] C_BLUE      = 2'd2;

    // Counter reloads with L-1 so the verdict lands exactly L edges after WRITE.
    localparam logic [3:0] CNT_INIT = 4'(TASTE_LATENCY - 1);

    typedef enum logic {IDLE, CHEW} state_t;

    typedef struct packed {
        logic [2:0] flavor;
        logic [1:0] color;
        logic       sugar_free;
        logic       sour;
    } recipe_t;

    state_t     state;
    logic [3:0] cnt;
    recipe_t    recipe;
    logic [1:0] taste_reg;
    logic [1:0] verdict;

    // Verdict rules on the captured recipe; first matching rule wins.
    always_comb begin
        verdict = T_YUMMY;
        if (recipe.color == 2'd3)
            verdict = T_UNKNOWN;
        else if (recipe.flavor == 3'd0 || recipe.flavor >= 3'd5)
            verdict = T_YUCKY;
        else if (recipe.flavor == F_CHOCOLATE && recipe.sour)
            verdict = T_YUCKY;
        else if (recipe.flavor == F_APPLE && recipe.color == C_BLUE)
            verdict = T_YUCKY;
        else if (recipe.sugar_free && recipe.sour)
            verdict = T_YUCKY;
    end

    // Taster FSM with registered taste/busy/statistics outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            recipe          <= '0;
            taste_reg       <= T_UNKNOWN;
            bus.taste       <= T_UNKNOWN;
            bus.busy        <= 1'b0;
            bus.yummy_count <= '0;
            bus.yucky_count <= '0;
        end else begin
            // Read is side-effect free and sees taste_reg before this edge.
            bus.taste <= (bus.command == CMD_READ) ? taste_reg : T_UNKNOWN;

            case (state)
                IDLE: begin
                    if (bus.command == CMD_WRITE) begin
                        recipe   <= '{flavor: bus.flavor, color: bus.color,
                                      sugar_free: bus.sugar_free, sour: bus.sour};
                        cnt      <= CNT_INIT;
                        state    <= CHEW;
                        bus.busy <= 1'b1;
                    end
                end
                CHEW: begin
                    // Writes arriving here are dropped; the master must honour busy.
                    if (cnt == 4'd0) begin
                        taste_reg <= verdict;
                        if (verdict == T_YUMMY && bus.yummy_count != 8'hFF)
                            bus.yummy_count <= bus.yummy_count + 8'd1;
                        if (verdict == T_YUCKY && bus.yucky_count != 8'hFF)
                            bus.yucky_count <= bus.yucky_count + 8'd1;
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/jelly_bean_taster.md
# jelly_bean_taster

Slave-side responder for the jelly bean bus: accepts recipe writes from the master, "chews" each recipe for a configurable number of cycles, records a verdict, and returns it on read. Sits at the `slave_mp` end of the jelly bean interface as the DUT that the master driver and the register model talk to. It also keeps saturating yummy/yucky statistics for the register model to mirror.

## Interface
- `TASTE_LATENCY`, default 2: chew duration in cycles; legal range 1..15.
- `clk`  input  1  sole clock; all state updates on its rising edge.
- `rst`  input  1  synchronous reset, active-high.
- `flavor`  input  3  0 NO_FLAVOR, 1 APPLE, 2 BLUEBERRY, 3 BUBBLE_GUM, 4 CHOCOLATE, 5..7 invalid.
- `color`  input  2  0 RED, 1 GREEN, 2 BLUE, 3 invalid.
- `sugar_free`  input  1  recipe attribute.
- `sour`  input  1  recipe attribute.
- `command`  input  2  0 NO_OP, 1 READ, 2 WRITE, 3 reserved (treated as NO_OP).
- `taste`  output  2  0 UNKNOWN, 1 YUMMY, 2 YUCKY; registered.
- `busy`  output  1  high while chewing; WRITEs ignored.
- `yummy_count`  output  8  saturating count of YUMMY verdicts.
- `yucky_count`  output  8  saturating count of YUCKY verdicts.

## Operation
- FSM states: IDLE, CHEW.
- IDLE + WRITE: capture flavor/color/sugar_free/sour into recipe register; load chew counter with TASTE_LATENCY-1; go CHEW.
- CHEW: if counter==0 -> compute verdict from recipe register, write taste_reg, bump matching count, go IDLE; else decrement counter.
- WRITE while in CHEW: dropped, no side effect (master must honour `busy`).
- Verdict, first match wins:
  - color==3 -> UNKNOWN; no count incremented.
  - flavor==0 or flavor>=5 -> YUCKY.
  - flavor==CHOCOLATE and sour -> YUCKY.
  - flavor==APPLE and color==BLUE -> YUCKY.
  - sugar_free and sour -> YUCKY.
  - otherwise -> YUMMY.
- Counters: 8-bit, saturate at 255, never wrap.
- READ (any state): `taste` <= taste_reg at that edge; otherwise `taste` <= UNKNOWN. Reading has no side effects.
- Reset: state IDLE, counter 0, recipe 0, taste_reg 0, `taste` 0, `busy` 0, `yummy_count` 0, `yucky_count` 0.
- Reset during CHEW: in-flight recipe abandoned; no verdict, no count update.

## Timing
- WRITE sampled at edge E0 (IDLE): `busy` high from E0 through E0+L (L = TASTE_LATENCY), i.e. L cycles.
- Verdict written to taste_reg and count updated at edge E0+L; state IDLE after E0+L.
- Next WRITE accepted at earliest at edge E0+L+1; back-to-back throughput one recipe per L+1 cycles.
- READ sampled at edge R: `taste` shows taste_reg value as of before R, valid for exactly one cycle after R, then returns to UNKNOWN unless READ repeats.
- READ at the same edge as verdict write (R = E0+L) returns the previous verdict; READ at E0+L+1 returns the new one.
- Consecutive READs hold `taste` steady with no UNKNOWN gap.
- `busy`, `taste`, counts all registered; no combinational input-to-output paths.

## Test plan
- Reset then idle 5 cycles -> `taste`=0, `busy`=0, both counts 0 throughout.
- L=2: WRITE APPLE/RED/sweet/not sour at E0, READ at E0+3 -> `busy` high 2 cycles, `taste`=1 for one cycle, `yummy_count`=1.
- WRITE CHOCOLATE/GREEN/sour, READ at E0+L and again at E0+L+1 -> first READ returns prior verdict (0 after reset), second returns 2; `yucky_count`=1.
- WRITE during CHEW with flavor=BLUEBERRY while first recipe is CHOCOLATE+sour -> second write ignored; verdict 2; only one count increments.
- Color=3 write -> verdict 0, neither count changes; flavor=6 write -> verdict 2.
- 260 YUMMY writes -> `yummy_count` sticks at 255; `rst` asserted mid-CHEW -> all outputs 0 next cycle, no count update.
